// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the shared 8-bit processor bus.
// Bytes are queued in a small FIFO and an interrupt is raised when the queue drains.
module bus_uart_tx #(
    parameter logic [7:0] BASE_ADDR    = 8'hB0,
    parameter int         CLKS_PER_BIT = 434,
    parameter int         FIFO_DEPTH   = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK,
    output logic       UART_TXD
);

    // state   | meaning
    // S_IDLE  | line idle high, waiting for tx_enable and queued data
    // S_START | start bit (low) for one bit period
    // S_DATA  | eight data bits, LSB first
    // S_STOP  | stop bit (high); may chain straight into the next start bit
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [15:0]      BAUD_LOAD = 16'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    state_t             state, state_n;
    logic [15:0]        baud_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift_reg;
    logic               baud_tc;
    logic               pop;
    logic               irq_event;

    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               fifo_empty, fifo_full, push_ok, ovf_set;

    logic [7:0]         offset;
    logic               in_win;
    logic [1:0]         reg_sel;
    logic               wr_txdata, wr_ctrl, clr_ovf;
    logic               tx_enable, irq_enable, ovf_flag, irq_q;
    logic               drive_en;
    logic [7:0]         rd_q, rd_data;

    assign offset    = BUS_ADDR - BASE_ADDR;
    assign in_win    = (offset[7:2] == 6'd0);
    assign reg_sel   = offset[1:0];
    assign wr_txdata = BUS_WE && in_win && (reg_sel == 2'd0);
    assign wr_ctrl   = BUS_WE && in_win && (reg_sel == 2'd2);
    assign clr_ovf   = wr_ctrl && BUS_DATA[2];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_C);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push_ok    = wr_txdata && (!fifo_full || pop);
    assign ovf_set    = wr_txdata && !push_ok;
    assign baud_tc    = (baud_cnt == 16'd0);

    always_ff @(posedge CLK) begin
        if (push_ok)
            fifo_mem[wr_ptr] <= BUS_DATA;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        irq_event = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_enable && !fifo_empty) begin
                    pop     = 1'b1;
                    state_n = S_START;
                end
            end
            S_START: begin
                if (baud_tc)
                    state_n = S_DATA;
            end
            S_DATA: begin
                if (baud_tc && (bit_cnt == 3'd7))
                    state_n = S_STOP;
            end
            S_STOP: begin
                if (baud_tc) begin
                    if (tx_enable && !fifo_empty) begin
                        pop     = 1'b1;
                        state_n = S_START;
                    end else begin
                        state_n   = S_IDLE;
                        irq_event = irq_enable && fifo_empty;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            baud_cnt  <= 16'd0;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
        end else begin
            state <= state_n;
            if (pop) begin
                shift_reg <= fifo_mem[rd_ptr];
                baud_cnt  <= BAUD_LOAD;
            end else if (state != S_IDLE) begin
                if (baud_tc) begin
                    baud_cnt <= BAUD_LOAD;
                    if (state == S_START)
                        bit_cnt <= 3'd0;
                    if (state == S_DATA) begin
                        bit_cnt   <= bit_cnt + 3'd1;
                        shift_reg <= {1'b0, shift_reg[7:1]};
                    end
                end else begin
                    baud_cnt <= baud_cnt - 16'd1;
                end
            end
        end
    end

    // Output decoded from flops only, so reset forces the line high immediately.
    always_comb begin
        UART_TXD = 1'b1;
        case (state)
            S_START: UART_TXD = 1'b0;
            S_DATA:  UART_TXD = shift_reg[0];
            default: UART_TXD = 1'b1;
        endcase
    end

    always_comb begin
        rd_data = 8'h00;
        case (reg_sel)
            2'd1:    rd_data = {4'(count), ovf_flag, (state != S_IDLE), fifo_full, fifo_empty};
            2'd2:    rd_data = {5'b00000, irq_enable, tx_enable};
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tx_enable  <= 1'b0;
            irq_enable <= 1'b0;
            ovf_flag   <= 1'b0;
            irq_q      <= 1'b0;
            drive_en   <= 1'b0;
            rd_q       <= 8'h00;
        end else begin
            if (wr_ctrl) begin
                tx_enable  <= BUS_DATA[0];
                irq_enable <= BUS_DATA[1];
            end
            if (ovf_set)
                ovf_flag <= 1'b1;
            else if (clr_ovf)
                ovf_flag <= 1'b0;
            if (irq_event)
                irq_q <= 1'b1;
            else if (BUS_INTERRUPT_ACK)
                irq_q <= 1'b0;
            drive_en <= in_win && !BUS_WE;
            if (in_win && !BUS_WE)
                rd_q <= rd_data;
        end
    end

    assign BUS_DATA            = drive_en ? rd_q : 8'hzz;
    assign BUS_INTERRUPT_RAISE = irq_q;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Scoreboard bench for bus_uart_tx: a line monitor decodes frames and the
// scenario tasks compare them against bytes queued when they were written.
module tb_bus_uart_tx;

    localparam int CPB = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bus_addr = 8'h00;
    logic       bus_we = 1'b0;
    logic       tb_oe = 1'b0;
    logic [7:0] tb_d = 8'h00;
    logic       ack = 1'b0;
    wire  [7:0] bus_data;
    wire        raise;
    wire        txd;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_data_q[$];
    int         rx_cyc_q[$];
    bit         rx_stop_q[$];

    assign bus_data = tb_oe ? tb_d : 8'hzz;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_uart_tx #(.BASE_ADDR(8'hB0), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(clk),
        .RESET(rst),
        .BUS_DATA(bus_data),
        .BUS_ADDR(bus_addr),
        .BUS_WE(bus_we),
        .BUS_INTERRUPT_RAISE(raise),
        .BUS_INTERRUPT_ACK(ack),
        .UART_TXD(txd)
    );

    // Line monitor: samples mid-bit and queues every complete frame.
    initial begin
        bit         act;
        int         k;
        int         st;
        logic [7:0] sh;
        act = 0; k = 0; st = 0; sh = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                act = 0;
            end else if (!act) begin
                if (txd === 1'b0) begin
                    act = 1; k = 0; st = cyc;
                end
            end else begin
                k++;
                if ((k % CPB == CPB / 2) && (k / CPB >= 1) && (k / CPB <= 8))
                    sh[k / CPB - 1] = txd;
                if (k == 9 * CPB + CPB / 2) begin
                    rx_data_q.push_back(sh);
                    rx_cyc_q.push_back(st);
                    rx_stop_q.push_back(txd === 1'b1);
                    act = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        bus_addr = a; bus_we = 1'b1; tb_oe = 1'b1; tb_d = d;
        @(negedge clk);
        bus_we = 1'b0; tb_oe = 1'b0; bus_addr = 8'h00;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        bus_addr = a; bus_we = 1'b0;
        @(negedge clk);
        d = bus_data;
        bus_addr = 8'h00;
        @(negedge clk);
    endtask

    task automatic wait_start(input int budget, output int waited);
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (rx_data_q.size() >= n) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (rx_data_q.size() >= n) ok = 1;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b required 1", txd); end
        n_tests++;
        if (raise !== 1'b0) begin n_fail++; $display("FAIL reset_raise: got %b required 0", raise); end
        rst = 1'b0;
        @(negedge clk);
        bus_addr = 8'hB1; bus_we = 1'b0;
        @(negedge clk);
        d = bus_data;
        n_tests++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL reset_status: got %h required 01", d); end
        // Another peripheral's write: only the bench value may appear on the bus.
        bus_addr = 8'h10; bus_we = 1'b1; tb_oe = 1'b1; tb_d = 8'h00;
        @(negedge clk);
        d = bus_data;
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL bus_release: got %h required 00 (dut not driving)", d); end
        bus_addr = 8'h00; bus_we = 1'b0; tb_oe = 1'b0;
        @(negedge clk);
        bus_read(8'hB2, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl: got %h required 00", d); end
        bus_read(8'hB0, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL txdata_read: got %h required 00", d); end
        bus_write(8'hB3, 8'hFF);
        bus_read(8'hB3, d);
        n_tests++;
        if (d !== 8'h00) begin n_fail++; $display("FAIL reserved_read: got %h required 00", d); end
    endtask

    task automatic test_single_frame();
        logic [7:0] d;
        logic [7:0] sd;
        logic [9:0] fr;
        logic       r39;
        int         w;
        int         bad[10];
        bit         ok;
        bus_write(8'hB2, 8'h03);
        bus_read(8'hB2, d);
        n_tests++;
        if (d !== 8'h03) begin n_fail++; $display("FAIL ctrl_readback: got %h required 03", d); end
        fr = {1'b1, 8'hA5, 1'b0};
        bus_write(8'hB0, 8'hA5);
        exp_q.push_back(8'hA5);
        wait_start(8, w);
        n_tests++;
        if (w != 1) begin n_fail++; $display("FAIL start_latency: got %0d required 1", w); end
        for (int b = 0; b < 10; b++) bad[b] = 0;
        sd = 8'h00; r39 = 1'bx;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) @(negedge clk);
            if (txd !== fr[k / CPB]) bad[k / CPB]++;
            if (k == 10) begin bus_addr = 8'hB1; bus_we = 1'b0; end
            if (k == 11) begin sd = bus_data; bus_addr = 8'h00; end
            if (k == 39) r39 = raise;
        end
        for (int b = 0; b < 10; b++) begin
            n_tests++;
            if (bad[b] != 0) begin
                n_fail++;
                $display("FAIL txd_bit%0d: got %0d wrong cycles, required level %b for %0d cycles", b, bad[b], fr[b], CPB);
            end
        end
        n_tests++;
        if (sd !== 8'h05) begin n_fail++; $display("FAIL status_busy: got %h required 05", sd); end
        n_tests++;
        if (r39 !== 1'b0) begin n_fail++; $display("FAIL raise_early: got %b required 0", r39); end
        @(negedge clk);
        n_tests++;
        if (raise !== 1'b1) begin n_fail++; $display("FAIL raise_after_stop: got %b required 1", raise); end
        wait_rx(1, 20, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL frame_a5_timeout: got %0d frames required 1", rx_data_q.size());
        end else begin
            d = rx_data_q.pop_front();
            void'(rx_cyc_q.pop_front());
            void'(rx_stop_q.pop_front());
            sd = exp_q.pop_front();
            n_tests++;
            if (d !== sd) begin n_fail++; $display("FAIL frame_a5: got %h required %h", d, sd); end
        end
    endtask

    task automatic test_irq_ack();
        repeat (3) @(negedge clk);
        n_tests++;
        if (raise !== 1'b1) begin n_fail++; $display("FAIL raise_held: got %b required 1", raise); end
        bus_write(8'hB2, 8'h01);
        @(negedge clk);
        n_tests++;
        if (raise !== 1'b1) begin n_fail++; $display("FAIL raise_irq_disable: got %b required 1", raise); end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_tests++;
        if (raise !== 1'b0) begin n_fail++; $display("FAIL raise_ack: got %b required 0", raise); end
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic [7:0] e;
        bit         ok;
        bus_write(8'hB2, 8'h00);
        for (int i = 0; i < 9; i++) bus_write(8'hB0, 8'h10 + 8'(i));
        bus_read(8'hB1, d);
        n_tests++;
        if (d !== 8'h8A) begin n_fail++; $display("FAIL status_overflow: got %h required 8a", d); end
        bus_write(8'hB2, 8'h04);
        bus_read(8'hB1, d);
        n_tests++;
        if (d !== 8'h82) begin n_fail++; $display("FAIL status_clr_ovf: got %h required 82", d); end
        for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
        bus_write(8'hB2, 8'h01);
        wait_rx(8, 8 * 10 * CPB + 40, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL drain_timeout: got %0d frames required 8", rx_data_q.size()); end
        for (int i = 0; i < 8; i++) begin
            if (rx_data_q.size() == 0 || exp_q.size() == 0) break;
            d = rx_data_q.pop_front();
            void'(rx_cyc_q.pop_front());
            void'(rx_stop_q.pop_front());
            e = exp_q.pop_front();
            n_tests++;
            if (d !== e) begin n_fail++; $display("FAIL drain_frame%0d: got %h required %h", i, d, e); end
        end
        exp_q.delete();
        repeat (60) @(negedge clk);
        n_tests++;
        if (rx_data_q.size() != 0) begin n_fail++; $display("FAIL dropped_byte_sent: got %0d extra frames required 0", rx_data_q.size()); end
        rx_data_q.delete(); rx_cyc_q.delete(); rx_stop_q.delete();
        bus_read(8'hB1, d);
        n_tests++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL status_drained: got %h required 01", d); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0, d1, e0, e1;
        int         c0, c1;
        bit         s0, s1;
        bit         ok;
        bus_write(8'hB0, 8'h00);
        exp_q.push_back(8'h00);
        bus_write(8'hB0, 8'hFF);
        exp_q.push_back(8'hFF);
        wait_rx(2, 150, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL b2b_timeout: got %0d frames required 2", rx_data_q.size());
        end else begin
            d0 = rx_data_q.pop_front(); c0 = rx_cyc_q.pop_front(); s0 = rx_stop_q.pop_front();
            d1 = rx_data_q.pop_front(); c1 = rx_cyc_q.pop_front(); s1 = rx_stop_q.pop_front();
            e0 = exp_q.pop_front(); e1 = exp_q.pop_front();
            n_tests++;
            if (d0 !== e0) begin n_fail++; $display("FAIL b2b_frame0: got %h required %h", d0, e0); end
            n_tests++;
            if (d1 !== e1) begin n_fail++; $display("FAIL b2b_frame1: got %h required %h", d1, e1); end
            n_tests++;
            if (c1 - c0 != 10 * CPB) begin n_fail++; $display("FAIL b2b_spacing: got %0d cycles required %0d", c1 - c0, 10 * CPB); end
            n_tests++;
            if (!(s0 && s1)) begin n_fail++; $display("FAIL b2b_stop_bits: got %b%b required 11", s0, s1); end
        end
        repeat (10) @(negedge clk);
        n_tests++;
        if (raise !== 1'b0) begin n_fail++; $display("FAIL raise_irq_disabled: got %b required 0", raise); end
    endtask

    task automatic test_irq_coincident();
        logic [7:0] d, e;
        int         w;
        bit         ok;
        bus_write(8'hB2, 8'h03);
        bus_write(8'hB0, 8'h3C);
        exp_q.push_back(8'h3C);
        wait_start(8, w);
        n_tests++;
        if (w < 0) begin n_fail++; $display("FAIL start_3c_timeout: got no start required start within 8 cycles"); end
        repeat (10 * CPB) @(negedge clk);
        n_tests++;
        if (raise !== 1'b1) begin n_fail++; $display("FAIL raise_first: got %b required 1", raise); end
        bus_write(8'hB0, 8'hC3);
        exp_q.push_back(8'hC3);
        wait_start(8, w);
        n_tests++;
        if (w < 0) begin n_fail++; $display("FAIL start_c3_timeout: got no start required start within 8 cycles"); end
        repeat (10 * CPB - 1) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_tests++;
        if (raise !== 1'b1) begin n_fail++; $display("FAIL raise_ack_coincident: got %b required 1", raise); end
        @(negedge clk);
        n_tests++;
        if (raise !== 1'b1) begin n_fail++; $display("FAIL raise_after_coincident: got %b required 1", raise); end
        wait_rx(2, 20, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL irq_frames_timeout: got %0d frames required 2", rx_data_q.size()); end
        for (int i = 0; i < 2; i++) begin
            if (rx_data_q.size() == 0 || exp_q.size() == 0) break;
            d = rx_data_q.pop_front();
            void'(rx_cyc_q.pop_front());
            void'(rx_stop_q.pop_front());
            e = exp_q.pop_front();
            n_tests++;
            if (d !== e) begin n_fail++; $display("FAIL irq_frame%0d: got %h required %h", i, d, e); end
        end
        exp_q.delete();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_tests++;
        if (raise !== 1'b0) begin n_fail++; $display("FAIL raise_final_ack: got %b required 0", raise); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        int         w;
        int         lows;
        bus_write(8'hB2, 8'h01);
        bus_write(8'hB0, 8'h52);
        bus_write(8'hB0, 8'h77);
        wait_start(8, w);
        n_tests++;
        if (w < 0) begin n_fail++; $display("FAIL start_52_timeout: got no start required start within 8 cycles"); end
        // Cycle 17 of the frame lies inside data bit 3, which is 0 for 0x52.
        repeat (17) @(negedge clk);
        n_tests++;
        if (txd !== 1'b0) begin n_fail++; $display("FAIL pre_reset_txd: got %b required 0", txd); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL txd_async_reset: got %b required 1", txd); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus_read(8'hB1, d);
        n_tests++;
        if (d !== 8'h01) begin n_fail++; $display("FAIL status_after_abort: got %h required 01", d); end
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
        end
        n_tests++;
        if (lows != 0) begin n_fail++; $display("FAIL idle_after_abort: got %0d non-idle cycles required 0", lows); end
        n_tests++;
        if (rx_data_q.size() != 0) begin n_fail++; $display("FAIL frames_after_abort: got %0d frames required 0", rx_data_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_irq_ack();
        test_overflow();
        test_back_to_back();
        test_irq_coincident();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
